// File: rtl/cpu_pkg.sv
// Shared CPU constants for the instruction memory path.
//   INST_ADDR_WIDTH / INST_DATA_WIDTH : instruction memory geometry (word addressed)
//   INST_NOP                          : word presented when no real fetch data exists
//   imem_ld_state_e                   : load controller FSM encoding
//   imem_range_legal()                : load range check, evaluated without wrap-around
package cpu_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 8;
  localparam int unsigned INST_DATA_WIDTH = 32;
  localparam logic [INST_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    LdIdle = 2'd0,
    LdLoad = 2'd1,
    LdRun  = 2'd2
  } imem_ld_state_e;

  // Two extra bits so base + len can reach 2**INST_ADDR_WIDTH without wrapping.
  function automatic logic imem_range_legal(input logic [INST_ADDR_WIDTH-1:0] base,
                                            input logic [INST_ADDR_WIDTH:0]   len);
    logic [INST_ADDR_WIDTH+1:0] end_w;
    end_w = {2'b00, base} + {1'b0, len};
    return (len != '0) && (end_w <= {2'b01, {INST_ADDR_WIDTH{1'b0}}});
  endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch and program-load bus of the instruction memory controller.
//   master : fetch stage / loader (drives requests and the load stream)
//   slave  : imem_ctrl (returns fetch data and load status)
interface imem_ctrl_if;
  import cpu_pkg::*;

  logic                       Imem_En;
  logic [INST_ADDR_WIDTH-1:0] Imem_Addr;
  logic [INST_DATA_WIDTH-1:0] Imem_Data;
  logic                       Rd_Valid;
  logic                       Ld_Start;
  logic [INST_ADDR_WIDTH-1:0] Ld_Base;
  logic [INST_ADDR_WIDTH:0]   Ld_Len;
  logic                       Ld_Valid;
  logic [INST_DATA_WIDTH-1:0] Ld_Data;
  logic                       Ld_Ready;
  logic                       Ld_Done;
  logic                       Ld_Err;

  modport master (
    output Imem_En, Imem_Addr, Ld_Start, Ld_Base, Ld_Len, Ld_Valid, Ld_Data,
    input  Imem_Data, Rd_Valid, Ld_Ready, Ld_Done, Ld_Err
  );

  modport slave (
    input  Imem_En, Imem_Addr, Ld_Start, Ld_Base, Ld_Len, Ld_Valid, Ld_Data,
    output Imem_Data, Rd_Valid, Ld_Ready, Ld_Done, Ld_Err
  );

endinterface

// File: rtl/imem_ctrl_sram_1p.sv
// sram_1p: single-port synchronous-read word array, no reset on contents.
//   clk_i   : clock
//   we_i    : write mem[addr_i] <= wdata_i
//   re_i    : rdata_o <= mem[addr_i]; rdata_o holds when re_i is low
//   addr_i  : shared read/write address
//   wdata_i : write data
//   rdata_o : registered read data
module sram_1p #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory with a program-load front end.
//   Clk, Rst_n : clock, synchronous active-low reset
//   bus        : imem_ctrl_if.slave -- fetch port (Imem_En/Addr -> Imem_Data/Rd_Valid, one cycle)
//                and load port (Ld_Start/Base/Len, Ld_Valid/Data/Ready, Ld_Done, Ld_Err)
// IDLE waits for a legal load, LOAD streams words into the array, RUN serves fetches.
module imem_ctrl
  import cpu_pkg::*;
(
  input logic        Clk,
  input logic        Rst_n,
  imem_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = LdIdle;
  localparam logic [1:0] StLoad = LdLoad;
  localparam logic [1:0] StRun  = LdRun;

  logic [1:0]                 state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [INST_ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       rd_valid_q, rd_valid_d;
  // Set while the output must show INST_NOP instead of the array read register.
  logic                       nop_q, nop_d;

  logic                       ld_legal;
  logic                       mem_we;
  logic                       mem_re;
  logic [INST_ADDR_WIDTH-1:0] mem_addr;
  logic [INST_DATA_WIDTH-1:0] mem_rdata;

  assign ld_legal = imem_range_legal(bus.Ld_Base, bus.Ld_Len);
  // Writes only happen in LOAD and reads only in RUN, so the port is never shared.
  assign mem_we   = (state_q == StLoad) && bus.Ld_Valid;
  assign mem_re   = (state_q == StRun) && bus.Imem_En;
  assign mem_addr = mem_we ? ptr_q : bus.Imem_Addr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StIdle, StRun: begin
        if (bus.Ld_Start) begin
          if (ld_legal) begin
            state_d = StLoad;
            ptr_d   = bus.Ld_Base;
            cnt_d   = bus.Ld_Len;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (mem_we) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == {{INST_ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_valid_d = mem_re;
    nop_d      = nop_q;
    if (mem_re) begin
      nop_d = 1'b0;
    end else if (bus.Imem_En) begin
      nop_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      nop_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      nop_q      <= nop_d;
    end
  end

  sram_1p #(
    .AddrWidth(INST_ADDR_WIDTH),
    .DataWidth(INST_DATA_WIDTH)
  ) u_sram (
    .clk_i  (Clk),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(bus.Ld_Data),
    .rdata_o(mem_rdata)
  );

  // Idle fetch cycles leave nop_q and the read register untouched, so data holds.
  assign bus.Imem_Data = nop_q ? INST_NOP : mem_rdata;
  assign bus.Rd_Valid  = rd_valid_q;
  assign bus.Ld_Ready  = (state_q == StLoad);
  assign bus.Ld_Done   = (state_q == StRun);
  assign bus.Ld_Err    = err_q;

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;
  import cpu_pkg::*;

  localparam int AW    = INST_ADDR_WIDTH;
  localparam int Words = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_ctrl_if bus();

  imem_ctrl u_dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: memory image plus a queue of addresses still owed by the load.
  logic [31:0] m_mem [Words];
  bit          m_known [Words];
  int          m_wq [$];
  bit          m_loading, m_done, m_err, m_valid, m_data_known;
  logic [31:0] m_data = INST_NOP;
  int          accepts = 0;
  bit          last_ready = 1'b0;

  typedef struct {
    int base;
    int len;
    bit err;
  } rng_t;
  rng_t rng_tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int a, b, l;
    if (last_ready && bus.Ld_Valid) accepts++;
    if (!rst_n) begin
      m_loading    = 1'b0;
      m_done       = 1'b0;
      m_err        = 1'b0;
      m_wq.delete();
      m_data       = INST_NOP;
      m_data_known = 1'b1;
      m_valid      = 1'b0;
    end else begin
      if (bus.Imem_En) begin
        if (m_done) begin
          m_data       = m_mem[bus.Imem_Addr];
          m_data_known = m_known[bus.Imem_Addr];
          m_valid      = 1'b1;
        end else begin
          m_data       = INST_NOP;
          m_data_known = 1'b1;
          m_valid      = 1'b0;
        end
      end else begin
        m_valid = 1'b0;
      end
      if (m_loading) begin
        if (bus.Ld_Valid) begin
          a = m_wq.pop_front();
          m_mem[a]   = bus.Ld_Data;
          m_known[a] = 1'b1;
          if (m_wq.size() == 0) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
          end
        end
      end else if (bus.Ld_Start) begin
        b = int'(bus.Ld_Base);
        l = int'(bus.Ld_Len);
        if (l != 0 && b + l <= Words) begin
          m_err     = 1'b0;
          m_loading = 1'b1;
          m_done    = 1'b0;
          for (int i = 0; i < l; i++) m_wq.push_back(b + i);
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("rd_valid", bus.Rd_Valid, m_valid);
    if (m_data_known) chk("imem_data", bus.Imem_Data, m_data);
    chk("ld_ready", bus.Ld_Ready, m_loading);
    chk("ld_done", bus.Ld_Done, m_done);
    chk("ld_err", bus.Ld_Err, m_err);
    last_ready = bus.Ld_Ready;
  endtask

  task automatic idle_inputs();
    bus.Imem_En   = 1'b0;
    bus.Imem_Addr = '0;
    bus.Ld_Start  = 1'b0;
    bus.Ld_Base   = '0;
    bus.Ld_Len    = '0;
    bus.Ld_Valid  = 1'b0;
    bus.Ld_Data   = '0;
  endtask

  task automatic start(input int base, input int len);
    bus.Ld_Start = 1'b1;
    bus.Ld_Base  = AW'(base);
    bus.Ld_Len   = (AW+1)'(len);
    tick();
    bus.Ld_Start = 1'b0;
  endtask

  // Streams {tag, 1..len}; bubble=1 drops Ld_Valid every other cycle.
  task automatic feed(input int len, input int bubble, input logic [15:0] tag);
    int sent, budget;
    sent   = 0;
    budget = 0;
    while (sent < len && budget < 4 * len + 10) begin
      bus.Ld_Valid = (bubble == 0) || (budget % 2 == 1);
      bus.Ld_Data  = {tag, 16'(sent + 1)};
      tick();
      if (bus.Ld_Valid) sent++;
      budget++;
    end
    bus.Ld_Valid = 1'b0;
  endtask

  task automatic fetch_chk(input string name, input int addr, input logic [31:0] exp);
    bus.Imem_En   = 1'b1;
    bus.Imem_Addr = AW'(addr);
    tick();
    bus.Imem_En   = 1'b0;
    chk(name, bus.Imem_Data, exp);
    chk({name, "_valid"}, bus.Rd_Valid, 32'd1);
  endtask

  initial begin
    int a0;
    rng_tbl[0] = '{base: 'hFE, len: 3,   err: 1'b1};
    rng_tbl[1] = '{base: 'h00, len: 0,   err: 1'b1};
    rng_tbl[2] = '{base: 'hFF, len: 2,   err: 1'b1};
    rng_tbl[3] = '{base: 'h01, len: 256, err: 1'b1};
    rng_tbl[4] = '{base: 'h00, len: 256, err: 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_data", bus.Imem_Data, INST_NOP);
    chk("rst_flags", {bus.Rd_Valid, bus.Ld_Ready, bus.Ld_Done, bus.Ld_Err}, 32'd0);
    rst_n = 1'b1;

    // Fetch in IDLE, then keep fetching through the whole load.
    bus.Imem_En   = 1'b1;
    bus.Imem_Addr = 8'h11;
    tick();
    chk("idle_fetch_data", bus.Imem_Data, INST_NOP);
    chk("idle_fetch_valid", bus.Rd_Valid, 32'd0);

    start('h10, 3);
    for (int i = 0; i < 3; i++) begin
      bus.Ld_Valid = 1'b1;
      bus.Ld_Data  = 32'hAAAA_0001 + 32'(i);
      tick();
      chk("load_fetch_data", bus.Imem_Data, INST_NOP);
      chk("load_fetch_valid", bus.Rd_Valid, 32'd0);
      if (i < 2) chk("done_early", bus.Ld_Done, 32'd0);
    end
    bus.Ld_Valid = 1'b0;
    chk("done_after_3rd", bus.Ld_Done, 32'd1);
    tick();
    bus.Imem_En = 1'b0;
    chk("first_read_data", bus.Imem_Data, 32'hAAAA_0002);
    chk("first_read_valid", bus.Rd_Valid, 32'd1);

    // Bubbled 4-word load.
    a0 = accepts;
    start('h20, 4);
    feed(4, 1, 16'hBBBB);
    chk("bubble_accepts", 32'(accepts - a0), 32'd4);
    chk("bubble_done", bus.Ld_Done, 32'd1);
    fetch_chk("bubble_read", 'h23, 32'hBBBB_0004);
    fetch_chk("bubble_read0", 'h20, 32'hBBBB_0001);

    // Range legality from IDLE: illegal ones keep IDLE, the last one clears Ld_Err.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start(rng_tbl[i].base, rng_tbl[i].len);
      chk($sformatf("range_err[%0d]", i), bus.Ld_Err, 32'(rng_tbl[i].err));
      chk($sformatf("range_ready[%0d]", i), bus.Ld_Ready, 32'(!rng_tbl[i].err));
    end
    feed(256, 0, 16'hC000);
    chk("full_done", bus.Ld_Done, 32'd1);
    fetch_chk("full_read_lo", 'h00, 32'hC000_0001);
    fetch_chk("full_read_hi", 'hFF, 32'hC000_0100);
    fetch_chk("full_read_mid", 'h7F, 32'hC000_0080);

    // Reset part-way through a reload keeps the words already written.
    start('h40, 5);
    feed(5, 0, 16'h1111);
    start('h40, 5);
    feed(2, 0, 16'h2222);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_done", bus.Ld_Done, 32'd0);
    chk("midrst_ready", bus.Ld_Ready, 32'd0);
    start('h60, 1);
    feed(1, 0, 16'h5555);
    fetch_chk("midrst_new", 'h41, 32'h2222_0002);
    fetch_chk("midrst_old", 'h42, 32'h1111_0003);
    start('h40, 5);
    feed(5, 0, 16'h3333);
    for (int i = 0; i < 5; i++) fetch_chk("reload5", 'h40 + i, {16'h3333, 16'(i + 1)});

    // Reload from RUN with a fetch in the same cycle as Ld_Start.
    bus.Imem_En   = 1'b1;
    bus.Imem_Addr = 8'h41;
    start('h40, 2);
    bus.Imem_En = 1'b0;
    chk("run_reload_done", bus.Ld_Done, 32'd0);
    chk("run_reload_old", bus.Imem_Data, 32'h3333_0002);
    chk("run_reload_valid", bus.Rd_Valid, 32'd1);
    feed(2, 0, 16'h4444);
    fetch_chk("run_reload_new", 'h41, 32'h4444_0002);
    fetch_chk("run_reload_kept", 'h42, 32'h3333_0003);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.Ld_Start  = ($urandom_range(0, 29) == 0);
      bus.Ld_Base   = AW'($urandom);
      bus.Ld_Len    = ($urandom_range(0, 3) == 0) ? (AW+1)'($urandom)
                                                  : (AW+1)'($urandom_range(1, 24));
      bus.Ld_Valid  = 1'($urandom);
      bus.Ld_Data   = $urandom;
      bus.Imem_En   = 1'($urandom);
      bus.Imem_Addr = AW'($urandom);
      tick();
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-002 Rst_n  input  1  reset, synchronous, active-low.
REQ-003 Imem_En  input  1  fetch read request from the fetch stage.
REQ-004 Imem_Addr  input  INST_ADDR_WIDTH  word address of the fetch.
REQ-005 Imem_Data  output  INST_DATA_WIDTH  fetched instruction word.
REQ-006 Rd_Valid  output  1  Imem_Data holds a real memory word this cycle.
REQ-007 Ld_Start  input  1  one-cycle pulse that opens a program load.
REQ-008 Ld_Base  input  INST_ADDR_WIDTH  first word address of the load, sampled with Ld_Start.
REQ-009 Ld_Len  input  INST_ADDR_WIDTH+1  word count of the load, sampled with Ld_Start.
REQ-010 Ld_Valid / Ld_Data  input  1 / INST_DATA_WIDTH  load word stream.
REQ-011 Ld_Ready  output  1  controller accepts a load word this cycle.
REQ-012 Ld_Done  output  1  level; memory is loaded and reads are served (gates core Start).
REQ-013 Ld_Err  output  1  sticky; the last Ld_Start carried an illegal range.

Function
REQ-014 The controller SHALL implement the FSM IDLE, LOAD, RUN; reset state is IDLE.
REQ-015 In IDLE, Ld_Start with a legal range SHALL move the FSM to LOAD next cycle, latching the base into the pointer and the length into the remaining count.
REQ-016 A range SHALL be legal iff Ld_Len != 0 and Ld_Base + Ld_Len <= 2**INST_ADDR_WIDTH, computed at INST_ADDR_WIDTH+2 bits with no wrap.
REQ-017 An illegal Ld_Start SHALL set Ld_Err and leave the state unchanged; a later legal Ld_Start SHALL clear Ld_Err.
REQ-018 In LOAD, Ld_Ready SHALL be 1; each cycle with Ld_Valid & Ld_Ready SHALL write Ld_Data to mem[pointer], increment the pointer and decrement the count.
REQ-019 The transfer that accepts the last word (count == 1) SHALL move the FSM to RUN next cycle; Ld_Done rises in that same cycle.
REQ-020 Ld_Start during LOAD SHALL be ignored, with no change to the pointer, the count or Ld_Err.
REQ-021 Ld_Start in RUN with a legal range SHALL re-enter LOAD next cycle; Ld_Done SHALL drop in that cycle.
REQ-022 Ld_Ready SHALL be 0 in IDLE and RUN; Ld_Valid there SHALL be ignored.
REQ-023 In RUN, Imem_En=1 at cycle N SHALL drive Imem_Data=mem[Imem_Addr] with Rd_Valid=1 in cycle N+1 (1-cycle synchronous read latency).
REQ-024 In RUN, Imem_En=0 SHALL hold Imem_Data at its previous value with Rd_Valid=0 in the next cycle.
REQ-025 Imem_En in IDLE or LOAD SHALL give Imem_Data=INST_NOP and Rd_Valid=0 in the next cycle; the memory SHALL never be read and written in the same cycle.
REQ-026 A read accepted in the last RUN cycle before a re-load SHALL still complete normally in the following cycle.

Reset
REQ-027 Rst_n=0 at a posedge SHALL force the FSM to IDLE, Imem_Data=INST_NOP, and Rd_Valid, Ld_Ready, Ld_Done, Ld_Err, pointer and count to 0.
REQ-028 The memory array SHALL NOT be cleared by reset; a reset during LOAD abandons the load and keeps the words already written.

Structure
REQ-029 cpu_pkg SHALL hold INST_ADDR_WIDTH, INST_DATA_WIDTH, INST_NOP and the FSM enum imem_ld_state_e.
REQ-030 Storage SHALL be a sub-module sram_1p: a single-port, synchronous-read array of 2**INST_ADDR_WIDTH words with write-enable and read-enable; imem_ctrl holds the FSM, the pointer, the counter and the output muxing.

Verification (bench INST_ADDR_WIDTH=8, INST_NOP=32'h00000013)
REQ-031 Check the following directed load-and-read case:
- Stimulus: Ld_Start with base 0x10, len 3; words AAAA0001..AAAA0003 with Ld_Valid held; then Imem_En with Addr 0x11.
- Required response: Ld_Done rises 1 cycle after the 3rd accept; the next cycle gives Imem_Data=AAAA0002 and Rd_Valid=1.
REQ-032 Check Ld_Valid bubbles: a 4-word load with Ld_Valid toggling every other cycle -> exactly 4 writes, and Ld_Done is high only after the 4th accept.
REQ-033 Check range errors:
- Ld_Start with base 0xFE, len 3 -> Ld_Err=1, state stays IDLE.
- Ld_Start with len 0 -> Ld_Err=1.
- Then base 0x00, len 256 -> Ld_Err clears and all 256 words load.
REQ-034 Check reads before and during load: Imem_En=1 in IDLE and in LOAD -> Imem_Data=00000013 and Rd_Valid=0 every cycle.
REQ-035 Check reset mid-load: Rst_n=0 after 2 of 5 words -> IDLE with Ld_Done=0; a new 5-word load then reads back the new data, and mem[base+2..] keeps its old contents until it is rewritten.
REQ-036 Check reload from RUN: Ld_Start in RUN -> Ld_Done drops next cycle, a fetch issued in that same cycle returns the old word, and later fetches return the new word after the reload completes.
